// File: rtl/fractal_axis_packer.sv
// fractal_axis_packer
// Repacks the colour-stage pixel stream (frame_start / line_end / data_enable,
// no backpressure) into AXI4-Stream video with tuser = SOF and tlast = EOL.
// A small FIFO absorbs downstream stalls. The last FIFO slot is the output
// register itself, so every m_axis_* signal comes straight from a flop.
// If the FIFO overflows, the rest of the frame is dropped and the block
// waits for the next frame start before it writes again.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_SYNC | out of sync; discard beats until a frame_start beat arrives
// ST_RUN  | in frame; every beat is written (or dropped on overflow)
// ST_DROP | overflowed; discard the rest of the frame, FIFO keeps draining
module fractal_axis_packer #(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          frame_start_in,
  input  logic                          line_end_in,
  input  logic                          data_enable_in,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tuser,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  input  logic                          clear_overflow,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   frames_out
);

  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1;
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int RAM_DEPTH = FIFO_DEPTH - 1;   // one slot lives in the output register
  localparam int ENTRY_W   = DATA_WIDTH + 2;   // {tlast, tuser, tdata}

  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RAM_DEPTH - 1);
  localparam logic [15:0]      FRM_ONE  = 16'd1;

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_RUN  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [ENTRY_W-1:0]   mem_q [RAM_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]     ram_cnt_q, ram_cnt_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic                 out_valid_q, out_valid_d;
  logic [ENTRY_W-1:0]   out_entry_q, out_entry_d;
  logic                 overflow_q, overflow_d;
  logic [15:0]          frames_q, frames_d;

  logic [ENTRY_W-1:0]   entry_in;
  logic                 beat;
  logic                 pop;
  logic                 space;
  logic                 wr_en;
  logic                 drop;
  logic                 ram_wr;
  logic                 ram_rd;
  logic                 load_out;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  assign entry_in = {line_end_in, frame_start_in, data_in};
  assign beat     = data_enable_in;
  assign pop      = out_valid_q & m_axis_tready;
  // A pop in the same cycle frees a slot, so a full FIFO can still take a beat.
  assign space    = (level_q != LVL_FULL) | pop;

  // Frame-sync FSM: decides whether this cycle's beat is written, discarded or dropped.
  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    drop    = 1'b0;
    case (state_q)
      ST_SYNC, ST_DROP: begin
        if (beat && frame_start_in) begin
          if (space) begin
            wr_en   = 1'b1;
            state_d = ST_RUN;
          end else begin
            drop    = 1'b1;
            state_d = ST_DROP;
          end
        end
      end
      ST_RUN: begin
        if (beat) begin
          if (space) begin
            wr_en = 1'b1;
          end else begin
            drop    = 1'b1;
            state_d = ST_DROP;
          end
        end
      end
      default: state_d = ST_SYNC;
    endcase
  end

  // FIFO datapath: refill the output register from the RAM, or bypass the
  // incoming beat straight into it when the RAM is empty.
  always_comb begin
    out_valid_d = out_valid_q;
    out_entry_d = out_entry_q;
    ram_wr      = 1'b0;
    ram_rd      = 1'b0;
    load_out    = ~out_valid_q | pop;
    if (load_out) begin
      if (ram_cnt_q != '0) begin
        ram_rd      = 1'b1;
        ram_wr      = wr_en;
        out_valid_d = 1'b1;
        out_entry_d = mem_q[rd_ptr_q];
      end else if (wr_en) begin
        out_valid_d = 1'b1;
        out_entry_d = entry_in;
      end else begin
        out_valid_d = 1'b0;
      end
    end else begin
      ram_wr = wr_en;
    end
  end

  // Pointer, occupancy and status bookkeeping.
  always_comb begin
    wr_ptr_d  = ram_wr ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d  = ram_rd ? ptr_inc(rd_ptr_q) : rd_ptr_q;

    ram_cnt_d = ram_cnt_q;
    case ({ram_wr, ram_rd})
      2'b10:   ram_cnt_d = ram_cnt_q + LVL_ONE;
      2'b01:   ram_cnt_d = ram_cnt_q - LVL_ONE;
      default: ram_cnt_d = ram_cnt_q;
    endcase

    level_d = level_q;
    case ({wr_en, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase

    // A drop in the same cycle as a clear request wins, so no loss goes unreported.
    overflow_d = drop | (overflow_q & ~clear_overflow);

    frames_d = frames_q;
    if (pop && out_entry_q[DATA_WIDTH]) begin
      frames_d = frames_q + FRM_ONE;
    end
  end

  // Control and output registers; reset discards all FIFO content.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_SYNC;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_cnt_q   <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      out_entry_q <= '0;
      overflow_q  <= 1'b0;
      frames_q    <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_cnt_q   <= ram_cnt_d;
      level_q     <= level_d;
      out_valid_q <= out_valid_d;
      out_entry_q <= out_entry_d;
      overflow_q  <= overflow_d;
      frames_q    <= frames_d;
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset is needed.
  always_ff @(posedge clk) begin
    if (ram_wr) begin
      mem_q[wr_ptr_q] <= entry_in;
    end
  end

  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tdata  = out_entry_q[DATA_WIDTH-1:0];
  assign m_axis_tuser  = out_entry_q[DATA_WIDTH];
  assign m_axis_tlast  = out_entry_q[DATA_WIDTH+1];
  assign overflow      = overflow_q;
  assign fifo_level    = level_q;
  assign frames_out    = frames_q;

endmodule

// File: tb/tb_fractal_axis_packer.sv
// Testbench for fractal_axis_packer: a cycle-exact vector table followed by
// frame-level sequences checked against a queue of expected beats.
module tb_fractal_axis_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] data_in = '0;
  logic        frame_start_in = 1'b0;
  logic        line_end_in = 1'b0;
  logic        data_enable_in = 1'b0;
  logic [23:0] m_axis_tdata;
  logic        m_axis_tuser;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        clear_overflow = 1'b0;
  logic        overflow;
  logic [4:0]  fifo_level;
  logic [15:0] frames_out;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  bit rand_ready = 1'b0;

  logic [25:0] exp_q [$];
  bit          stall_prev = 1'b0;
  logic [25:0] held;

  fractal_axis_packer #(.DATA_WIDTH(24), .FIFO_DEPTH(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .data_in        (data_in),
    .frame_start_in (frame_start_in),
    .line_end_in    (line_end_in),
    .data_enable_in (data_enable_in),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tuser   (m_axis_tuser),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .clear_overflow (clear_overflow),
    .overflow       (overflow),
    .fifo_level     (fifo_level),
    .frames_out     (frames_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        de;
    logic        fs;
    logic        le;
    logic [23:0] data;
    logic        rdy;
    logic        exp_valid;
    logic        exp_user;
    logic        exp_last;
    logic [23:0] exp_data;
    logic [4:0]  exp_level;
    logic [15:0] exp_frames;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Stream monitor: sampled on the falling edge, i.e. the values the next rising edge will see.
  always @(negedge clk) begin
    if (reset || !mon_en) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checks++;
        if (!(m_axis_tvalid && {m_axis_tlast, m_axis_tuser, m_axis_tdata} == held)) begin
          errors++;
          $display("FAIL stall_hold: got valid=%0b beat=0x%0h expected valid=1 beat=0x%0h",
                   m_axis_tvalid, {m_axis_tlast, m_axis_tuser, m_axis_tdata}, held);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got 0x%0h expected no beat",
                   {m_axis_tlast, m_axis_tuser, m_axis_tdata});
        end else begin
          logic [25:0] e;
          e = exp_q.pop_front();
          if ({m_axis_tlast, m_axis_tuser, m_axis_tdata} !== e) begin
            errors++;
            $display("FAIL beat: got 0x%0h expected 0x%0h",
                     {m_axis_tlast, m_axis_tuser, m_axis_tdata}, e);
          end
        end
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      held       = {m_axis_tlast, m_axis_tuser, m_axis_tdata};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_pix(input logic fs, input logic le, input logic [23:0] d, input bit push);
    data_enable_in = 1'b1;
    frame_start_in = fs;
    line_end_in    = le;
    data_in        = d;
    if (push) exp_q.push_back({le, fs, d});
    tick();
    data_enable_in = 1'b0;
    frame_start_in = 1'b0;
    line_end_in    = 1'b0;
  endtask

  task automatic send_frame(input int w, input int h, input logic [23:0] base, input int gap);
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        send_pix((x == 0 && y == 0), (x == w - 1), base + 24'(y * w + x), 1'b1);
        idle(gap);
      end
    end
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    data_enable_in = 1'b0;
    frame_start_in = 1'b0;
    line_end_in    = 1'b0;
    clear_overflow = 1'b0;
    m_axis_tready  = 1'b0;
    exp_q.delete();
    idle(2);
    reset = 1'b0;
    tick();
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (!(exp_q.size() == 0 && fifo_level == 0) && n < 3000) begin
      tick();
      n++;
    end
    check({name, "_pending"}, 64'(exp_q.size()), 64'd0);
    check({name, "_level"}, 64'(fifo_level), 64'd0);
  endtask

  initial begin
    //            de fs le data        rdy  vld usr lst exp_data    lvl frames
    vecs[0] = '{1'b1, 1'b0, 1'b0, 24'h0000AA, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000, 5'd0, 16'd0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 24'h000001, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000001, 5'd1, 16'd0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 24'h000002, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000001, 5'd2, 16'd0};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b1, 1'b0, 1'b1, 24'h000002, 5'd1, 16'd1};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 24'h000003, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000003, 5'd1, 16'd1};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 24'hFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000003, 5'd1, 16'd1};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000, 5'd0, 16'd1};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 24'h000004, 1'b0, 1'b1, 1'b1, 1'b1, 24'h000004, 5'd1, 16'd1};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000, 5'd0, 16'd2};

    // Reset state
    do_reset();
    check("reset_outputs",
          {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata, overflow, fifo_level, frames_out},
          64'd0);

    // Cycle-exact vector table
    for (int i = 0; i < 9; i++) begin
      data_enable_in = vecs[i].de;
      frame_start_in = vecs[i].fs;
      line_end_in    = vecs[i].le;
      data_in        = vecs[i].data;
      m_axis_tready  = vecs[i].rdy;
      tick();
      check($sformatf("vec%0d_valid", i), 64'(m_axis_tvalid), 64'(vecs[i].exp_valid));
      check($sformatf("vec%0d_level", i), 64'(fifo_level), 64'(vecs[i].exp_level));
      check($sformatf("vec%0d_frames", i), 64'(frames_out), 64'(vecs[i].exp_frames));
      if (vecs[i].exp_valid)
        check($sformatf("vec%0d_beat", i), {m_axis_tlast, m_axis_tuser, m_axis_tdata},
              {vecs[i].exp_last, vecs[i].exp_user, vecs[i].exp_data});
    end
    data_enable_in = 1'b0;
    frame_start_in = 1'b0;
    line_end_in    = 1'b0;

    mon_en = 1'b1;

    // 4x4 frame with tready held high
    do_reset();
    m_axis_tready = 1'b1;
    send_frame(4, 4, 24'h000001, 0);
    wait_drain("t1");
    check("t1_frames", 64'(frames_out), 64'd1);
    check("t1_overflow", 64'(overflow), 64'd0);

    // Pixels before the first frame start are discarded
    do_reset();
    m_axis_tready = 1'b1;
    for (int i = 0; i < 3; i++) send_pix(1'b0, (i == 2), 24'h0A0000 + 24'(i), 1'b0);
    idle(2);
    check("t2_prestart_valid", 64'(m_axis_tvalid), 64'd0);
    send_frame(4, 4, 24'h000100, 0);
    wait_drain("t2");
    check("t2_frames", 64'(frames_out), 64'd1);

    // Overflow: 16 beats fill the FIFO, the 17th and the rest of the frame are dropped
    do_reset();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 32; i++) begin
      send_pix((i == 0), (i % 4 == 3), 24'h000200 + 24'(i), (i < 16));
      if (i == 15) begin
        check("t3_full_level", 64'(fifo_level), 64'd16);
        check("t3_full_overflow", 64'(overflow), 64'd0);
      end
      if (i == 16) begin
        check("t3_drop_level", 64'(fifo_level), 64'd16);
        check("t3_drop_overflow", 64'(overflow), 64'd1);
      end
    end
    m_axis_tready = 1'b1;
    wait_drain("t3a");
    check("t3_sticky", 64'(overflow), 64'd1);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check("t3_cleared", 64'(overflow), 64'd0);
    send_frame(4, 4, 24'h000300, 0);
    wait_drain("t3b");
    check("t3_frames", 64'(frames_out), 64'd2);

    // Full FIFO with a simultaneous pop accepts the beat
    do_reset();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 16; i++) send_pix((i == 0), (i % 4 == 3), 24'h000400 + 24'(i), 1'b1);
    check("t4_full_level", 64'(fifo_level), 64'd16);
    m_axis_tready = 1'b1;
    send_pix(1'b0, 1'b0, 24'h000410, 1'b1);
    check("t4_level_kept", 64'(fifo_level), 64'd16);
    check("t4_no_overflow", 64'(overflow), 64'd0);
    wait_drain("t4");
    check("t4_frames", 64'(frames_out), 64'd1);

    // Random tready over three 64x8 frames
    do_reset();
    rand_ready = 1'b1;
    for (int f = 0; f < 3; f++) send_frame(64, 8, 24'h100000 * 24'(f + 1), 3);
    wait_drain("t5");
    rand_ready = 1'b0;
    check("t5_frames", 64'(frames_out), 64'd3);
    check("t5_overflow", 64'(overflow), 64'd0);

    // Reset in the middle of a line with five entries held
    do_reset();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 5; i++) send_pix((i == 0), 1'b0, 24'h000500 + 24'(i), 1'b0);
    check("t6_level_before", 64'(fifo_level), 64'd5);
    #2;
    reset = 1'b1;
    #1;
    check("t6_reset_outputs",
          {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata, overflow, fifo_level, frames_out},
          64'd0);
    exp_q.delete();
    idle(2);
    reset = 1'b0;
    m_axis_tready = 1'b1;
    for (int i = 5; i < 8; i++) send_pix(1'b0, (i == 7), 24'h000500 + 24'(i), 1'b0);
    idle(2);
    check("t6_resync_valid", 64'(m_axis_tvalid), 64'd0);
    send_frame(4, 2, 24'h000600, 0);
    wait_drain("t6");
    check("t6_frames", 64'(frames_out), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
